// File: rtl/memoredf_config_port.sv
// AXI4-Lite register file holding the MemorEDF scheduler configuration: control word,
// read-only status word and a per-channel period table, with a one-cycle update pulse.
module memoredf_config_port #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           N_CHANNELS = 4,
    parameter int unsigned           PERIOD_W   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'hC000_0000),
    parameter logic [7:0]            VERSION    = 8'h02
) (
    input  logic                           i_aclk,
    input  logic                           i_areset,
    input  logic [ADDR_WIDTH-1:0]          i_s_axi_awaddr,
    input  logic                           i_s_axi_awvalid,
    output logic                           o_s_axi_awready,
    input  logic [DATA_WIDTH-1:0]          i_s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]        i_s_axi_wstrb,
    input  logic                           i_s_axi_wvalid,
    output logic                           o_s_axi_wready,
    output logic [1:0]                     o_s_axi_bresp,
    output logic                           o_s_axi_bvalid,
    input  logic                           i_s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]          i_s_axi_araddr,
    input  logic                           i_s_axi_arvalid,
    output logic                           o_s_axi_arready,
    output logic [DATA_WIDTH-1:0]          o_s_axi_rdata,
    output logic [1:0]                     o_s_axi_rresp,
    output logic                           o_s_axi_rvalid,
    input  logic                           i_s_axi_rready,
    output logic                           o_cfg_enable,
    output logic [1:0]                     o_cfg_mode,
    output logic [N_CHANNELS*PERIOD_W-1:0] o_cfg_period,
    output logic                           o_cfg_update
);

    localparam int unsigned      NBytes     = DATA_WIDTH / 8;
    localparam int unsigned      WordW      = ADDR_WIDTH - 2;
    localparam logic [WordW-1:0] BaseWord   = BASE_ADDR[ADDR_WIDTH-1:2];
    localparam logic [WordW-1:0] ChFirst    = WordW'(2);
    localparam logic [WordW-1:0] ChEnd      = WordW'(2 + N_CHANNELS);
    localparam logic [1:0]       RespOkay   = 2'b00;
    localparam logic [1:0]       RespSlvErr = 2'b10;

    typedef enum logic [1:0] {WIdle, WHaveA, WHaveD, WResp} w_state_e;
    typedef enum logic [0:0] {RIdle, RData} r_state_e;

    w_state_e              r_wstate;
    r_state_e              r_rstate;
    logic                  r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
    logic [1:0]            r_bresp, r_rresp;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0] r_wdata, r_rdata;
    logic [NBytes-1:0]     r_wstrb;
    logic [2:0]            r_ctrl;
    logic [PERIOD_W-1:0]   r_period [N_CHANNELS];
    logic                  r_upd_pend, r_update;

    logic                  w_aw_hs, w_w_hs, w_ar_hs, w_commit;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data, w_wr_old, w_wr_merged;
    logic [NBytes-1:0]     w_wr_strb;
    logic [WordW-1:0]      w_wr_word, w_wr_ch, w_rd_word, w_rd_ch;
    logic                  w_wr_below, w_wr_ctrl, w_wr_chan, w_wr_ok;
    logic                  w_rd_below, w_rd_err;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_unused_bits;

    assign w_aw_hs = i_s_axi_awvalid && r_awready;
    assign w_w_hs  = i_s_axi_wvalid && r_wready;
    assign w_ar_hs = i_s_axi_arvalid && r_arready;

    // A half-accepted write completes from the latched channel plus the live one.
    always_comb begin
        w_wr_addr = (r_wstate == WHaveA) ? r_awaddr : i_s_axi_awaddr;
        w_wr_data = (r_wstate == WHaveD) ? r_wdata : i_s_axi_wdata;
        w_wr_strb = (r_wstate == WHaveD) ? r_wstrb : i_s_axi_wstrb;
    end

    assign w_wr_below = w_wr_addr[ADDR_WIDTH-1:2] < BaseWord;
    assign w_wr_word  = w_wr_addr[ADDR_WIDTH-1:2] - BaseWord;
    assign w_wr_ctrl  = !w_wr_below && (w_wr_word == '0);
    assign w_wr_chan  = !w_wr_below && (w_wr_word >= ChFirst) && (w_wr_word < ChEnd);
    assign w_wr_ch    = w_wr_word - ChFirst;
    assign w_wr_ok    = w_wr_ctrl || w_wr_chan;

    assign w_commit = ((r_wstate == WIdle) && w_aw_hs && w_w_hs) ||
                      ((r_wstate == WHaveA) && w_w_hs) ||
                      ((r_wstate == WHaveD) && w_aw_hs);

    always_comb begin
        w_wr_old = DATA_WIDTH'(r_ctrl);
        for (int i = 0; i < N_CHANNELS; i++) begin
            if (w_wr_chan && (w_wr_ch == WordW'(i))) begin
                w_wr_old = DATA_WIDTH'(r_period[i]);
            end
        end
        for (int b = 0; b < NBytes; b++) begin
            w_wr_merged[b*8 +: 8] = w_wr_strb[b] ? w_wr_data[b*8 +: 8] : w_wr_old[b*8 +: 8];
        end
    end

    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            r_wstate   <= WIdle;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RespOkay;
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_ctrl     <= '0;
            r_upd_pend <= 1'b0;
            r_update   <= 1'b0;
            for (int i = 0; i < N_CHANNELS; i++) begin
                r_period[i] <= '0;
            end
        end else begin
            r_update   <= r_upd_pend;
            r_upd_pend <= 1'b0;
            case (r_wstate)
                WIdle: begin
                    if (w_commit) begin
                        r_wstate  <= WResp;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                    end else if (w_aw_hs) begin
                        r_wstate  <= WHaveA;
                        r_awaddr  <= i_s_axi_awaddr;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                    end else if (w_w_hs) begin
                        r_wstate  <= WHaveD;
                        r_wdata   <= i_s_axi_wdata;
                        r_wstrb   <= i_s_axi_wstrb;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b0;
                    end else begin
                        // Also the first cycle out of reset, when both readies are still low.
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                    end
                end
                WHaveA: begin
                    if (w_commit) begin
                        r_wstate <= WResp;
                        r_wready <= 1'b0;
                    end
                end
                WHaveD: begin
                    if (w_commit) begin
                        r_wstate  <= WResp;
                        r_awready <= 1'b0;
                    end
                end
                WResp: begin
                    if (i_s_axi_bready) begin
                        r_wstate  <= WIdle;
                        r_bvalid  <= 1'b0;
                        r_bresp   <= RespOkay;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                    end
                end
                default: r_wstate <= WIdle;
            endcase
            if (w_commit) begin
                r_bvalid   <= 1'b1;
                r_bresp    <= w_wr_ok ? RespOkay : RespSlvErr;
                r_upd_pend <= w_wr_ok;
                if (w_wr_ctrl) begin
                    r_ctrl <= w_wr_merged[2:0];
                end
                for (int i = 0; i < N_CHANNELS; i++) begin
                    if (w_wr_chan && (w_wr_ch == WordW'(i))) begin
                        r_period[i] <= w_wr_merged[PERIOD_W-1:0];
                    end
                end
            end
        end
    end

    assign w_rd_below = i_s_axi_araddr[ADDR_WIDTH-1:2] < BaseWord;
    assign w_rd_word  = i_s_axi_araddr[ADDR_WIDTH-1:2] - BaseWord;
    assign w_rd_ch    = w_rd_word - ChFirst;

    always_comb begin
        w_rd_data = '0;
        w_rd_err  = 1'b0;
        if (w_rd_below) begin
            w_rd_err = 1'b1;
        end else if (w_rd_word == '0) begin
            w_rd_data = DATA_WIDTH'(r_ctrl);
        end else if (w_rd_word == WordW'(1)) begin
            w_rd_data = DATA_WIDTH'({VERSION, 8'h00, 8'(N_CHANNELS), 7'h00, r_ctrl[0]});
        end else if ((w_rd_word >= ChFirst) && (w_rd_word < ChEnd)) begin
            for (int i = 0; i < N_CHANNELS; i++) begin
                if (w_rd_ch == WordW'(i)) begin
                    w_rd_data = DATA_WIDTH'(r_period[i]);
                end
            end
        end else begin
            w_rd_err = 1'b1;
        end
    end

    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            r_rstate  <= RIdle;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RespOkay;
        end else begin
            case (r_rstate)
                RIdle: begin
                    if (w_ar_hs) begin
                        r_rstate  <= RData;
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rdata   <= w_rd_data;
                        r_rresp   <= w_rd_err ? RespSlvErr : RespOkay;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                RData: begin
                    if (i_s_axi_rready) begin
                        r_rstate  <= RIdle;
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                    end
                end
                default: r_rstate <= RIdle;
            endcase
        end
    end

    always_comb begin
        o_cfg_period = '0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            o_cfg_period[i*PERIOD_W +: PERIOD_W] = r_period[i];
        end
    end

    // Byte-offset bits and discarded upper write bits have no function.
    assign w_unused_bits = ^{w_wr_addr[1:0], i_s_axi_araddr[1:0], w_wr_merged};

    assign o_s_axi_awready = r_awready;
    assign o_s_axi_wready  = r_wready;
    assign o_s_axi_bvalid  = r_bvalid;
    assign o_s_axi_bresp   = r_bresp;
    assign o_s_axi_arready = r_arready;
    assign o_s_axi_rvalid  = r_rvalid;
    assign o_s_axi_rdata   = r_rdata;
    assign o_s_axi_rresp   = r_rresp;
    assign o_cfg_enable    = r_ctrl[0];
    assign o_cfg_mode      = r_ctrl[2:1];
    assign o_cfg_update    = r_update;

endmodule

// File: tb/tb_memoredf_config_port.sv
// Randomised bench for memoredf_config_port against a transaction-level register model,
// with a per-cycle compare of the cfg_* outputs and directed literal checks.
module tb_memoredf_config_port;

    localparam logic [31:0] BASE = 32'hC000_0000;
    localparam int          NCH  = 4;
    localparam int          PW   = 16;

    logic              clk = 1'b0;
    logic              areset;
    logic [31:0]       awaddr, wdata, araddr, rdata;
    logic [3:0]        wstrb;
    logic              awvalid, awready, wvalid, wready, bvalid, bready;
    logic              arvalid, arready, rvalid, rready;
    logic [1:0]        bresp, rresp;
    logic              cfg_enable, cfg_update;
    logic [1:0]        cfg_mode;
    logic [NCH*PW-1:0] cfg_period;

    int          n_cmp   = 0;
    int          n_err   = 0;
    int          cyc     = 0;
    int          last_ok = -100;
    bit          mon_en  = 1'b0;
    logic [31:0] m_ctrl;
    logic [31:0] m_period [NCH];

    memoredf_config_port dut (
        .i_aclk          (clk),
        .i_areset        (areset),
        .i_s_axi_awaddr  (awaddr),
        .i_s_axi_awvalid (awvalid),
        .o_s_axi_awready (awready),
        .i_s_axi_wdata   (wdata),
        .i_s_axi_wstrb   (wstrb),
        .i_s_axi_wvalid  (wvalid),
        .o_s_axi_wready  (wready),
        .o_s_axi_bresp   (bresp),
        .o_s_axi_bvalid  (bvalid),
        .i_s_axi_bready  (bready),
        .i_s_axi_araddr  (araddr),
        .i_s_axi_arvalid (arvalid),
        .o_s_axi_arready (arready),
        .o_s_axi_rdata   (rdata),
        .o_s_axi_rresp   (rresp),
        .o_s_axi_rvalid  (rvalid),
        .i_s_axi_rready  (rready),
        .o_cfg_enable    (cfg_enable),
        .o_cfg_mode      (cfg_mode),
        .o_cfg_period    (cfg_period),
        .o_cfg_update    (cfg_update)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        m_ctrl = 32'h0;
        for (int i = 0; i < NCH; i++) m_period[i] = 32'h0;
        last_ok = -100;
    endfunction

    // Register map as plain arithmetic: word 0 CTRL, 1 STATUS, 2.. channel periods.
    function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data,
                                               input logic [3:0] strb);
        logic [31:0] word, nv;
        if (addr < BASE) return 2'b10;
        word = (addr - BASE) >> 2;
        if (word == 0) nv = m_ctrl;
        else if (word >= 2 && word < 2 + NCH) nv = m_period[word - 2];
        else return 2'b10;
        for (int b = 0; b < 4; b++) if (strb[b]) nv[b*8 +: 8] = data[b*8 +: 8];
        if (word == 0) m_ctrl = nv & 32'h7;
        else m_period[word - 2] = nv & ((32'h1 << PW) - 32'h1);
        return 2'b00;
    endfunction

    function automatic void model_read(input logic [31:0] addr, output logic [31:0] data,
                                       output logic [1:0] resp);
        logic [31:0] word;
        data = 32'h0;
        resp = 2'b10;
        if (addr >= BASE) begin
            word = (addr - BASE) >> 2;
            if (word == 0) begin
                data = m_ctrl; resp = 2'b00;
            end else if (word == 1) begin
                data = (32'h02 << 24) | (32'(NCH) << 8) | (m_ctrl & 32'h1); resp = 2'b00;
            end else if (word >= 2 && word < 2 + NCH) begin
                data = m_period[word - 2]; resp = 2'b00;
            end
        end
    endfunction

    function automatic logic [63:0] exp_period();
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < NCH; i++) v[i*PW +: PW] = m_period[i][PW-1:0];
        return v;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            chk("cfg_enable", 64'(cfg_enable), 64'(m_ctrl[0]));
            chk("cfg_mode", 64'(cfg_mode), 64'(m_ctrl[2:1]));
            chk("cfg_period", 64'(cfg_period), exp_period());
            chk("cfg_update", 64'(cfg_update), 64'(cyc == last_ok + 1));
        end
    end

    // w_lead > 0: W leads AW by w_lead cycles; < 0: AW leads W.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int w_lead, input int bdelay,
                            output logic [1:0] resp);
        int         aw_at, w_at, t;
        bit         aw_done, w_done, hs_aw, hs_w;
        logic [1:0] exp_resp;
        aw_at   = (w_lead > 0) ? w_lead : 0;
        w_at    = (w_lead < 0) ? -w_lead : 0;
        aw_done = 1'b0;
        w_done  = 1'b0;
        t       = 0;
        resp    = 2'b11;
        while (!(aw_done && w_done)) begin
            @(negedge clk);
            if (t > 40) begin
                n_cmp++;
                n_err++;
                $display("FAIL wr_accept_timeout: addr %h not accepted, required within 40 cycles",
                         addr);
                awvalid = 1'b0;
                wvalid  = 1'b0;
                return;
            end
            awaddr  = addr;
            wdata   = data;
            wstrb   = strb;
            awvalid = !aw_done && (t >= aw_at);
            wvalid  = !w_done && (t >= w_at);
            if (aw_done) chk("awready_after_aw", 64'(awready), 64'(0));
            if (w_done) chk("wready_after_w", 64'(wready), 64'(0));
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            @(posedge clk);
            aw_done = aw_done | hs_aw;
            w_done  = w_done | hs_w;
            t++;
        end
        #1;
        exp_resp = model_write(addr, data, strb);
        if (exp_resp == 2'b00) last_ok = cyc;
        @(negedge clk);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        resp    = bresp;
        for (int d = 0; d < 50; d++) begin
            chk("bvalid_held", 64'(bvalid), 64'(1));
            chk("bresp", 64'(bresp), 64'(exp_resp));
            chk("awready_in_resp", 64'(awready), 64'(0));
            chk("wready_in_resp", 64'(wready), 64'(0));
            if (d >= bdelay) begin
                bready = 1'b1;
                @(posedge clk);
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        bready = 1'b0;
        chk("bvalid_cleared", 64'(bvalid), 64'(0));
        chk("awready_after_b", 64'(awready), 64'(1));
        chk("wready_after_b", 64'(wready), 64'(1));
    endtask

    task automatic do_read(input logic [31:0] addr, input int rdelay,
                           output logic [31:0] data, output logic [1:0] resp);
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        bit          hs;
        int          t;
        t    = 0;
        hs   = 1'b0;
        data = 32'hX;
        resp = 2'b11;
        while (!hs) begin
            @(negedge clk);
            if (t > 40) begin
                n_cmp++;
                n_err++;
                $display("FAIL rd_accept_timeout: addr %h not accepted, required within 40 cycles",
                         addr);
                arvalid = 1'b0;
                return;
            end
            araddr  = addr;
            arvalid = 1'b1;
            model_read(addr, exp_data, exp_resp);
            hs = arready;
            @(posedge clk);
            t++;
        end
        @(negedge clk);
        arvalid = 1'b0;
        data    = rdata;
        resp    = rresp;
        for (int d = 0; d < 50; d++) begin
            chk("rvalid_held", 64'(rvalid), 64'(1));
            chk("rdata", 64'(rdata), 64'(exp_data));
            chk("rresp", 64'(rresp), 64'(exp_resp));
            chk("arready_in_data", 64'(arready), 64'(0));
            if (d >= rdelay) begin
                rready = 1'b1;
                @(posedge clk);
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        rready = 1'b0;
        chk("rvalid_cleared", 64'(rvalid), 64'(0));
        chk("arready_after_r", 64'(arready), 64'(1));
    endtask

    function automatic logic [31:0] rand_addr();
        int k;
        k = $urandom_range(0, 9);
        if (k <= 7) return BASE + 32'(4 * k) + 32'($urandom_range(0, 3));
        if (k == 8) return BASE - 32'(4 * $urandom_range(1, 3));
        return BASE + 32'h100;
    endfunction

    initial begin
        logic [1:0]  r1, r2;
        logic [31:0] d1;
        logic [31:0] a1, a2;
        areset  = 1'b1;
        awaddr  = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr  = '0; arvalid = 1'b0; rready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", 64'(awready), 64'(0));
        chk("rst_wready", 64'(wready), 64'(0));
        chk("rst_arready", 64'(arready), 64'(0));
        chk("rst_bvalid", 64'(bvalid), 64'(0));
        chk("rst_rvalid", 64'(rvalid), 64'(0));
        chk("rst_bresp", 64'(bresp), 64'(0));
        chk("rst_rresp", 64'(rresp), 64'(0));
        chk("rst_rdata", 64'(rdata), 64'(0));
        chk("rst_cfg_enable", 64'(cfg_enable), 64'(0));
        chk("rst_cfg_mode", 64'(cfg_mode), 64'(0));
        chk("rst_cfg_period", 64'(cfg_period), 64'(0));
        chk("rst_cfg_update", 64'(cfg_update), 64'(0));
        areset = 1'b0;
        @(negedge clk);
        chk("awready_out_of_reset", 64'(awready), 64'(1));
        chk("wready_out_of_reset", 64'(wready), 64'(1));
        chk("arready_out_of_reset", 64'(arready), 64'(1));
        mon_en = 1'b1;

        do_write(BASE, 32'h0000_0005, 4'hF, 0, 0, r1);
        chk("ctrl_wr_resp", 64'(r1), 64'(0));
        chk("ctrl_enable", 64'(cfg_enable), 64'(1));
        chk("ctrl_mode", 64'(cfg_mode), 64'(2'b10));

        do_write(BASE + 32'h08, 32'hABCD_1234, 4'hF, 2, 0, r1);
        do_write(BASE + 32'h14, 32'hABCD_1234, 4'hF, 2, 0, r2);
        chk("ch0_period_lit", 64'(cfg_period[15:0]), 64'(16'h1234));
        chk("ch3_period_lit", 64'(cfg_period[63:48]), 64'(16'h1234));
        do_read(BASE + 32'h08, 0, d1, r1);
        chk("ch0_readback", 64'(d1), 64'(32'h0000_1234));
        chk("ch0_readback_resp", 64'(r1), 64'(0));
        do_read(BASE + 32'h14, 0, d1, r1);
        chk("ch3_readback", 64'(d1), 64'(32'h0000_1234));

        do_write(BASE + 32'h0C, 32'h0000_1234, 4'hF, -1, 0, r1);
        do_write(BASE + 32'h0C, 32'hFFFF_FFFF, 4'b0010, 0, 0, r1);
        do_read(BASE + 32'h0C, 0, d1, r1);
        chk("ch1_byte_strobe", 64'(d1), 64'(32'h0000_FF34));
        do_write(BASE + 32'h0C, 32'hFFFF_FFFF, 4'b0000, 0, 0, r1);
        chk("zero_strobe_resp", 64'(r1), 64'(0));

        do_write(BASE + 32'h18, 32'hFFFF_FFFF, 4'hF, 0, 0, r1);
        chk("oob_wr_resp", 64'(r1), 64'(2'b10));
        do_write(BASE + 32'h04, 32'hFFFF_FFFF, 4'hF, 1, 0, r1);
        chk("status_wr_resp", 64'(r1), 64'(2'b10));
        do_read(32'hBFFF_FFFC, 0, d1, r1);
        chk("below_base_rresp", 64'(r1), 64'(2'b10));
        chk("below_base_rdata", 64'(d1), 64'(0));
        do_read(BASE + 32'h04, 0, d1, r1);
        chk("status_value", 64'(d1), 64'(32'h0200_0401));
        do_read(BASE, 0, d1, r1);
        chk("ctrl_unchanged", 64'(d1), 64'(32'h5));

        do_write(BASE + 32'h10, 32'h0000_0A0A, 4'hF, 0, 5, r1);
        do_read(BASE + 32'h10, 5, d1, r1);
        chk("stalled_read", 64'(d1), 64'(32'h0000_0A0A));

        // Same-edge write and read of CH_PERIOD[2]: read must see the old value.
        fork
            do_write(BASE + 32'h10, 32'h0000_5555, 4'hF, 0, 0, r2);
            do_read(BASE + 32'h10, 0, d1, r1);
        join
        chk("same_edge_old_value", 64'(d1), 64'(32'h0000_0A0A));

        // Reset while holding an accepted AW with no W.
        @(negedge clk);
        awaddr  = BASE + 32'h08;
        awvalid = 1'b1;
        chk("pre_rst_awready", 64'(awready), 64'(1));
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0;
        chk("have_a_awready", 64'(awready), 64'(0));
        chk("have_a_wready", 64'(wready), 64'(1));
        areset = 1'b1;
        @(posedge clk);
        #1 model_reset();
        @(negedge clk);
        chk("midrst_bvalid", 64'(bvalid), 64'(0));
        chk("midrst_awready", 64'(awready), 64'(0));
        chk("midrst_period", 64'(cfg_period), 64'(0));
        chk("midrst_enable", 64'(cfg_enable), 64'(0));
        areset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_no_b", 64'(bvalid), 64'(0));
        end
        do_write(BASE + 32'h08, 32'h0000_BEEF, 4'hF, 1, 0, r1);
        chk("post_rst_wr_resp", 64'(r1), 64'(0));
        chk("post_rst_ch0", 64'(cfg_period[15:0]), 64'(16'hBEEF));

        for (int it = 0; it < 150; it++) begin
            int op;
            op = $urandom_range(0, 2);
            a1 = rand_addr();
            a2 = rand_addr();
            if (op == 0) begin
                do_write(a1, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 4) - 2,
                         $urandom_range(0, 3), r1);
            end else if (op == 1) begin
                do_read(a2, $urandom_range(0, 3), d1, r2);
            end else begin
                fork
                    do_write(a1, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 4) - 2,
                             $urandom_range(0, 3), r1);
                    do_read(a2, $urandom_range(0, 3), d1, r2);
                join
            end
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
